// File: rtl/mcdf_pkg.sv
// Shared MCDF definitions: channel count, field widths, packet-length decode
// and the arbiter FSM state type.
package mcdf_pkg;

  localparam int CH_N     = 3;
  localparam int DATA_W   = 32;
  localparam int PRIO_W   = 2;
  localparam int PKGLEN_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  // Codes above 3 saturate at the largest packet size.
  function automatic logic [5:0] decode_len(input logic [PKGLEN_W-1:0] code);
    case (code)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/mcdf_arb_pick.sv
// Combinational channel selector: lowest priority value wins, ties resolved
// round-robin from the channel after rr_ptr. MCDF_ARB_AGING_EN adds an aged mask.
module mcdf_arb_pick #(
  parameter int PRIO_W = 2
) (
  input  logic [2:0]          elig,
  input  logic [3*PRIO_W-1:0] prio,
  input  logic [1:0]          rr_ptr,
`ifdef MCDF_ARB_AGING_EN
  input  logic [2:0]          aged,
`endif
  output logic [1:0]          win_id,
  output logic                found
);
  import mcdf_pkg::*;

  logic [2:0]        cand;
  logic [2:0]        sum;
  logic [1:0]        idx;
  logic [PRIO_W-1:0] best;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path through the loop can leave a latch behind.
  always_comb begin
    cand   = elig;
    win_id = '0;
    found  = 1'b0;
    best   = '1;
    sum    = '0;
    idx    = '0;
`ifdef MCDF_ARB_AGING_EN
    if (|(elig & aged)) cand = elig & aged;
`endif
    // Scan order starts after rr_ptr; strict '<' keeps the earliest equal-prio channel.
    for (int k = 1; k <= CH_N; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (cand[idx] && (!found || prio[idx*PRIO_W +: PRIO_W] < best)) begin
        found  = 1'b1;
        win_id = idx;
        best   = prio[idx*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF packet arbiter: grants one slave channel at a time and streams one packet
// of its configured length to the formatter. Optional aging: MCDF_ARB_AGING_EN.
module mcdf_arbiter #(
  parameter int DATA_W    = 32,
  parameter int PRIO_W    = 2,
  parameter int PKGLEN_W  = 3
`ifdef MCDF_ARB_AGING_EN
  ,
  parameter int AGE_LIMIT = 4
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            slv_en_i,
  input  logic [3*PRIO_W-1:0]   slv_prio_i,
  input  logic [3*PKGLEN_W-1:0] slv_pkglen_i,
  input  logic [2:0]            slv_val_i,
  input  logic [3*DATA_W-1:0]   slv_data_i,
  output logic [2:0]            slv_ack_o,
  output logic                  fmt_val_o,
  input  logic                  fmt_rdy_i,
  output logic [DATA_W-1:0]     fmt_data_o,
  output logic [1:0]            fmt_id_o,
  output logic [5:0]            fmt_len_o,
  output logic                  fmt_sop_o,
  output logic                  fmt_eop_o,
  output logic                  busy_o
);
  import mcdf_pkg::*;

  arb_state_e  state, state_nxt;
  logic [5:0]  cnt, gnt_len;
  logic [1:0]  gnt_id, rr_ptr, win_id;
  logic [2:0]  elig;
  logic        found, grant, xfer, last;

  assign elig  = slv_en_i & slv_val_i;
  assign grant = (state == IDLE) & found;
  assign last  = (cnt == gnt_len - 6'd1);

`ifdef MCDF_ARB_AGING_EN
  logic [2:0]      skip [CH_N];
  logic [CH_N-1:0] aged;

  // Skip counters are a handful of flops, so they are reset like any other state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CH_N; i++) skip[i] <= '0;
    end else if (grant) begin
      for (int i = 0; i < CH_N; i++) begin
        if (2'(i) == win_id)                  skip[i] <= '0;
        else if (elig[i] && skip[i] != 3'd7)  skip[i] <= skip[i] + 3'd1;
      end
    end
  end

  always_comb begin
    aged = '0;
    for (int i = 0; i < CH_N; i++) aged[i] = int'(skip[i]) >= AGE_LIMIT;
  end
`endif

  mcdf_arb_pick #(.PRIO_W(PRIO_W)) u_pick (
    .elig   (elig),
    .prio   (slv_prio_i),
    .rr_ptr (rr_ptr),
`ifdef MCDF_ARB_AGING_EN
    .aged   (aged),
`endif
    .win_id (win_id),
    .found  (found)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_id  <= '0;
      gnt_len <= 6'd4;
      rr_ptr  <= 2'd2;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_id  <= win_id;
        gnt_len <= decode_len(slv_pkglen_i[win_id*PKGLEN_W +: PKGLEN_W]);
        rr_ptr  <= win_id;
        cnt     <= '0;
      end else if (xfer) begin
        cnt <= cnt + 6'd1;
      end
    end
  end

  always_comb begin
    fmt_val_o  = 1'b0;
    fmt_data_o = '0;
    fmt_sop_o  = 1'b0;
    fmt_eop_o  = 1'b0;
    slv_ack_o  = '0;
    if (state == SEND) begin
      fmt_val_o         = slv_val_i[gnt_id];
      fmt_data_o        = slv_data_i[gnt_id*DATA_W +: DATA_W];
      fmt_sop_o         = (cnt == 6'd0) & fmt_val_o;
      fmt_eop_o         = last & fmt_val_o;
      slv_ack_o[gnt_id] = fmt_val_o & fmt_rdy_i;
    end
  end

  assign xfer = fmt_val_o & fmt_rdy_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = SEND;
      SEND:    if (xfer && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fmt_id_o  = gnt_id;
  assign fmt_len_o = gnt_len;
  assign busy_o    = (state == SEND);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Self-checking bench for mcdf_arbiter: slave FIFO models drive the inputs,
// directed tests push expected words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mcdf_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  slv_en_i = '0;
  logic [5:0]  slv_prio_i = '0;
  logic [8:0]  slv_pkglen_i = '0;
  logic [2:0]  slv_val_i = '0;
  logic [95:0] slv_data_i = '0;
  logic [2:0]  slv_ack_o;
  logic        fmt_val_o;
  logic        fmt_rdy_i = 1'b1;
  logic [31:0] fmt_data_o;
  logic [1:0]  fmt_id_o;
  logic [5:0]  fmt_len_o;
  logic        fmt_sop_o, fmt_eop_o, busy_o;

  mcdf_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .slv_en_i(slv_en_i), .slv_prio_i(slv_prio_i),
    .slv_pkglen_i(slv_pkglen_i), .slv_val_i(slv_val_i), .slv_data_i(slv_data_i),
    .slv_ack_o(slv_ack_o), .fmt_val_o(fmt_val_o), .fmt_rdy_i(fmt_rdy_i),
    .fmt_data_o(fmt_data_o), .fmt_id_o(fmt_id_o), .fmt_len_o(fmt_len_o),
    .fmt_sop_o(fmt_sop_o), .fmt_eop_o(fmt_eop_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [5:0]  len;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] fifo [3][$];
  logic [2:0]  hold = '0;
  logic [2:0]  ack_s = '0;
  int          load_seq [3];
  int          exp_seq [3];
  int          n_checks = 0;
  int          n_fail = 0;
  int          xfer_cnt = 0;
  int          base;

  function automatic logic [31:0] mkdata(input int ch, input int seq);
    return (32'(ch + 1) << 24) | 32'(seq);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic load(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      fifo[ch].push_back(mkdata(ch, load_seq[ch]));
      load_seq[ch]++;
    end
  endtask

  // Pushes the first n words of a len-word packet from channel ch.
  task automatic expect_words(input int ch, input int len, input int n);
    exp_t x;
    for (int j = 0; j < n; j++) begin
      x.id   = 2'(ch);
      x.data = mkdata(ch, exp_seq[ch]);
      x.sop  = (j == 0);
      x.eop  = (j == len - 1);
      x.len  = 6'(len);
      sb.push_back(x);
      exp_seq[ch]++;
    end
  endtask

  task automatic expect_pkt(input int ch, input int len);
    expect_words(ch, len, len);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_xfers(input string name, input int target, input int budget);
    int k = 0;
    while (xfer_cnt < target && k < budget) begin
      step();
      k++;
    end
    check({name, "_reached"}, 32'(xfer_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    slv_en_i     = '0;
    slv_prio_i   = '0;
    slv_pkglen_i = '0;
    fmt_rdy_i    = 1'b1;
    hold         = '0;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      fifo[c].delete();
      load_seq[c] = 0;
      exp_seq[c]  = 0;
    end
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
    check({name, "_val"},  32'(fmt_val_o), 32'd0);
    check({name, "_ack"},  32'(slv_ack_o), 32'd0);
    check({name, "_sop_eop"}, 32'({fmt_sop_o, fmt_eop_o}), 32'd0);
    check({name, "_id"},   32'(fmt_id_o), 32'd0);
    check({name, "_len"},  32'(fmt_len_o), 32'd4);
    check({name, "_data"}, fmt_data_o, 32'd0);
  endtask

  // Slave FIFO model: capture acks mid-cycle, pop after the edge, re-drive heads.
  initial begin
    forever begin
      @(negedge clk_i);
      ack_s = slv_ack_o;
      @(posedge clk_i);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (!rst_i && ack_s[c] && fifo[c].size() > 0) void'(fifo[c].pop_front());
        slv_val_i[c] = (fifo[c].size() > 0) && !hold[c];
        slv_data_i[c*32 +: 32] = (fifo[c].size() > 0) ? fifo[c][0] : 32'd0;
      end
    end
  end

  // Monitor: every formatter transfer must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (fmt_val_o && fmt_rdy_i) begin
          xfer_cnt++;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_xfer: got id %0d data 0x%0h, expected no transfer", fmt_id_o, fmt_data_o);
          end else begin
            e = sb.pop_front();
            check("xfer_id",   32'(fmt_id_o), 32'(e.id));
            check("xfer_data", fmt_data_o, e.data);
            check("xfer_sop",  32'(fmt_sop_o), 32'(e.sop));
            check("xfer_eop",  32'(fmt_eop_o), 32'(e.eop));
            check("xfer_len",  32'(fmt_len_o), 32'(e.len));
            check("xfer_ack",  32'(slv_ack_o), 32'(3'b001 << e.id));
          end
        end else begin
          check("idle_ack", 32'(slv_ack_o), 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and single packet with 1-cycle arbitration latency.
    do_reset();
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst0");
    step();
    rst_i = 1'b0;
    load(0, 4);
    step();
    slv_en_i = 3'b001;
    expect_pkt(0, 4);
    @(negedge clk_i);
    check("t1_no_grant_yet", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("t1_granted", 32'(busy_o), 32'd1);
    wait_drain("t1", 50);
    @(negedge clk_i);
    check("t1_busy_after", 32'(busy_o), 32'd0);

    // Priority with round-robin among the prio-0 channels; ch0 waits.
    do_reset();
    slv_prio_i = {2'd0, 2'd0, 2'd1};
    load(0, 4); load(1, 8); load(2, 8);
    step();
    slv_en_i = 3'b111;
    expect_pkt(1, 4); expect_pkt(2, 4); expect_pkt(1, 4); expect_pkt(2, 4); expect_pkt(0, 4);
    wait_drain("t2", 200);

    // Equal priorities from reset rotate 0,1,2,0.
    do_reset();
    slv_prio_i = {2'd2, 2'd2, 2'd2};
    load(0, 8); load(1, 4); load(2, 4);
    step();
    slv_en_i = 3'b111;
    expect_pkt(0, 4); expect_pkt(1, 4); expect_pkt(2, 4); expect_pkt(0, 4);
    wait_drain("t3", 200);

    // 32-word packet with formatter and slave stalls.
    do_reset();
    slv_pkglen_i = {3'd0, 3'd3, 3'd0};
    load(1, 32);
    step();
    slv_en_i = 3'b010;
    base = xfer_cnt;
    expect_pkt(1, 32);
    wait_xfers("t4_w10", base + 10, 100);
    fmt_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t4_rdy_hold_val",  32'(fmt_val_o), 32'd1);
      check("t4_rdy_hold_ack",  32'(slv_ack_o), 32'd0);
      check("t4_rdy_hold_data", fmt_data_o, mkdata(1, 10));
      step();
    end
    fmt_rdy_i = 1'b1;
    wait_xfers("t4_w20", base + 20, 100);
    hold[1] = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("t4_empty_val", 32'(fmt_val_o), 32'd0);
      check("t4_empty_busy", 32'(busy_o), 32'd1);
      step();
    end
    hold[1] = 1'b0;
    wait_drain("t4", 200);
    check("t4_total_xfers", 32'(xfer_cnt - base), 32'd32);

    // Config changes mid-packet apply only from the next grant.
    do_reset();
    load(2, 20);
    step();
    slv_en_i = 3'b100;
    base = xfer_cnt;
    expect_pkt(2, 4);
    wait_xfers("t5_w2", base + 2, 50);
    slv_pkglen_i = {3'd2, 3'd0, 3'd0};
    slv_en_i     = 3'b000;
    wait_drain("t5a", 50);
    repeat (8) step();
    @(negedge clk_i);
    check("t5_disabled_idle", 32'(busy_o), 32'd0);
    step();
    slv_en_i = 3'b100;
    expect_pkt(2, 16);
    wait_drain("t5b", 100);

    // Reset mid-packet abandons it; afterwards ch0 wins the 3-way tie.
    do_reset();
    slv_pkglen_i = {3'd1, 3'd1, 3'd1};
    load(0, 13); load(1, 8); load(2, 8);
    step();
    slv_en_i = 3'b111;
    base = xfer_cnt;
    expect_words(0, 8, 5);
    wait_xfers("t6_w5", base + 5, 50);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    step();
    step();
    rst_i = 1'b0;
    check("t6_sb_after_rst", 32'(sb.size()), 32'd0);
    expect_pkt(0, 8); expect_pkt(1, 8); expect_pkt(2, 8);
    wait_drain("t6", 200);

`ifdef MCDF_ARB_AGING_EN
    // Aging: ch1 promoted after 4 skipped grants, then its counter restarts.
    do_reset();
    slv_prio_i = {2'd0, 2'd3, 2'd0};
    load(0, 32); load(1, 8);
    step();
    slv_en_i = 3'b011;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) expect_pkt(0, 4);
      expect_pkt(1, 4);
    end
    wait_drain("t7", 400);
`endif

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
